decode_fetch_queue: RTL

- Parametrised instruction queue between the fetch and decode stages.
- Replaces the single pc/instr/exception hand-off register with a DEPTH-entry FIFO, so fetch keeps running while decode is stalled by a CSR write or memory wait.
- Adds flush on redirect (jump/clear), next-pc computation for 16/32-bit encodings, an almost-full indicator, and a fault-hold state that stops fetch after a faulting fetch.

---
 rtl/decode_fetch_queue_if.sv | 37 +++
 rtl/decode_fetch_queue.sv | 75 +++++++
 2 files changed

// File: rtl/decode_fetch_queue_if.sv
// decode_fetch_queue_if: fetch-side push and decode-side pop signals of the fetch/decode queue.
interface decode_fetch_queue_if #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4,
    parameter int ECW   = 4
);
    logic                     flush;
    logic                     in_valid;
    logic                     in_ready;
    logic [XLEN-1:0]          in_pc;
    logic [31:0]              in_instr;
    logic                     in_exception;
    logic [ECW-1:0]           in_ecause;
    logic [XLEN-1:0]          in_etval;
    logic                     out_valid;
    logic                     out_ready;
    logic [XLEN-1:0]          out_pc;
    logic [XLEN-1:0]          out_npc;
    logic [31:0]              out_instr;
    logic                     out_exception;
    logic [ECW-1:0]           out_ecause;
    logic [XLEN-1:0]          out_etval;
    logic [$clog2(DEPTH):0]   count;
    logic                     almost_full;

    modport slave (
        input  flush, in_valid, in_pc, in_instr, in_exception, in_ecause, in_etval, out_ready,
        output in_ready, out_valid, out_pc, out_npc, out_instr, out_exception, out_ecause,
               out_etval, count, almost_full
    );

    modport master (
        output flush, in_valid, in_pc, in_instr, in_exception, in_ecause, in_etval, out_ready,
        input  in_ready, out_valid, out_pc, out_npc, out_instr, out_exception, out_ecause,
               out_etval, count, almost_full
    );
endinterface

// File: rtl/decode_fetch_queue.sv
// decode_fetch_queue: DEPTH-entry fetch-to-decode FIFO with flush, next-pc and fault hold.
module decode_fetch_queue #(
    parameter int XLEN     = 32,
    parameter int DEPTH    = 4,
    parameter int ECW      = 4,
    parameter int AF_LEVEL = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    decode_fetch_queue_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic {RUN, HOLD} state_e;

    logic [XLEN-1:0] pc_q     [DEPTH];
    logic [31:0]     instr_q  [DEPTH];
    logic            exc_q    [DEPTH];
    logic [ECW-1:0]  ecause_q [DEPTH];
    logic [XLEN-1:0] etval_q  [DEPTH];
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    state_e          state_q, state_d;
    logic            push, pop;

    assign bus.in_ready      = (count_q < CW'(DEPTH)) & (state_q == RUN);
    assign bus.out_valid     = count_q != '0;
    assign bus.out_pc        = pc_q[rd_ptr_q];
    assign bus.out_instr     = instr_q[rd_ptr_q];
    assign bus.out_exception = exc_q[rd_ptr_q];
    assign bus.out_ecause    = ecause_q[rd_ptr_q];
    assign bus.out_etval     = etval_q[rd_ptr_q];
    assign bus.out_npc       = pc_q[rd_ptr_q] + ((instr_q[rd_ptr_q][1:0] == 2'b11) ? XLEN'(4) : XLEN'(2));
    assign bus.count         = count_q;
    assign bus.almost_full   = count_q >= CW'(AF_LEVEL);

    // A faulting push parks the queue in HOLD until a redirect flushes it.
    always_comb begin
        push     = bus.in_valid & bus.in_ready;
        pop      = bus.out_valid & bus.out_ready;
        rd_ptr_d = bus.flush ? '0 : rd_ptr_q + AW'(pop);
        wr_ptr_d = bus.flush ? '0 : wr_ptr_q + AW'(push);
        count_d  = bus.flush ? '0 : count_q + CW'(push) - CW'(pop);
        state_d  = bus.flush ? RUN : (push & bus.in_exception) ? HOLD : state_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            state_q  <= RUN;
            for (int i = 0; i < DEPTH; i++) begin
                pc_q[i]     <= '0;
                instr_q[i]  <= '0;
                exc_q[i]    <= 1'b0;
                ecause_q[i] <= '0;
                etval_q[i]  <= '0;
            end
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            state_q  <= state_d;
            if (push & ~bus.flush) begin
                pc_q[wr_ptr_q]     <= bus.in_pc;
                instr_q[wr_ptr_q]  <= bus.in_instr;
                exc_q[wr_ptr_q]    <= bus.in_exception;
                ecause_q[wr_ptr_q] <= bus.in_ecause;
                etval_q[wr_ptr_q]  <= bus.in_etval;
            end
        end
    end
endmodule
